ee357_iter_shifter: RTL and testbench
=====================================

// Module: ee357_iter_shifter
// PURPOSE
//  Parametrised multicycle shifter for the ee357 datapath; generalises the fixed
//  left-shift-by-2 unit to any width, run-time shift amount and four shift modes.
//  Shifts STEP bits per clock under a start/busy/done handshake, so a wide shift
//  trades latency for area. Sits beside the ALU and is sequenced by the control FSM.
// PARAMETERS
//  WIDTH    32             operand/result width in bits (>=2)
//  SHAMT_W  $clog2(WIDTH)  shift-amount width; derived, do not override
//  STEP     1              bits shifted per cycle; power of 2, 1..WIDTH
// PORTS
//  clk     in   1        rising-edge clock
//  rst_n   in   1        synchronous active-low reset
//  start   in   1        request; accepted only in IDLE or DONE
//  mode    in   2        0=SLL 1=SRL 2=SRA 3=ROR; sampled with start
//  shamt   in   SHAMT_W  shift amount; sampled with start
//  in      in   WIDTH    operand; sampled with start
//  busy    out  1        high while state==SHIFT
//  done    out  1        one-cycle pulse, out valid
//  out     out  WIDTH    result; held from done until next accepted start
// BEHAVIOUR
//  - Reset (rst_n low at posedge): state=IDLE, busy=0, done=0, out=0, rem=0;
//    reset mid-shift aborts; no done is produced for the aborted request.
//  - States IDLE -> SHIFT -> DONE -> IDLE; DONE -> SHIFT/DONE on back-to-back start.
//  - Accept (start=1 in IDLE/DONE): latch in->acc, mode, rem=shamt;
//    next state SHIFT if shamt!=0, else DONE.
//  - SHIFT: k=min(STEP,rem); acc shifted by k per mode; rem-=k; go DONE when rem==k.
//  - DONE: done=1, out=acc; return to IDLE unless start accepted.
//  - Latency: done high exactly ceil(shamt/STEP)+1 cycles after the accept edge;
//    shamt=0 gives 1 cycle, out=in.
//  - start while busy is ignored: no effect on acc/rem/mode.
//  - Modes: SLL fill 0 from LSB; SRL fill 0 from MSB; SRA replicate acc[WIDTH-1];
//    ROR bits leaving LSB enter MSB. Bits shifted past either end are discarded
//    (except ROR); no carry/overflow output.
//  - out only changes on the DONE transition or reset; busy and done never both high.
// STRUCTURE
//  - ee357_shift_defs.vh: localparams MODE_SLL/SRL/SRA/ROR, ST_IDLE/SHIFT/DONE.
//  - Sub-module ee357_shift_step: combinational (acc, mode, k) -> acc shifted by
//    k, k<=STEP. Top holds FSM, acc, rem and out registers.
// TESTING (WIDTH=32 unless noted; one self-checking bench, $stop on any failure)
//  1 SLL in=0x00000003 shamt=2 STEP=1 -> done on cycle 3, out=0x0000000C.
//  2 SLL in=0xC0000000 shamt=2 -> out=0x00000000 (MSBs discarded).
//  3 SRA in=0x80000000 shamt=31 STEP=4 -> done on cycle 9, out=0xFFFFFFFF;
//    SRL same input -> out=0x00000001.
//  4 ROR in=0x00000001 shamt=1 -> out=0x80000000; shamt=0 any mode -> done on
//    cycle 1, out=in.
//  5 SLL in=1 shamt=8 STEP=1; start with in=0xFFFFFFFF at cycle 3 -> ignored,
//    out=0x00000100 on cycle 9; start in the DONE cycle is accepted.
//  6 rst_n low at cycle 4 of an 8-cycle shift -> next edge busy=0, done=0,
//    out=0; no done pulse follows.

Source files
------------

// File: rtl/ee357_iter_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ee357_iter_shifter_pkg
// Description : Shared definitions for the ee357 iterative shifter. Holds the
//               shift-mode encodings and the control FSM state type used by
//               the top level and the per-cycle shift stage.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ee357_iter_shifter_pkg;

  // Shift-mode encodings as presented on the mode port
  localparam logic [1:0] MODE_SLL = 2'd0;
  localparam logic [1:0] MODE_SRL = 2'd1;
  localparam logic [1:0] MODE_SRA = 2'd2;
  localparam logic [1:0] MODE_ROR = 2'd3;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ee357_iter_shifter_step.sv
`default_nettype none
// ============================================================================
// Module      : ee357_iter_shifter_step
// Description : Combinational shift stage. Shifts acc by k bit positions
//               (k <= STEP) according to mode: SLL, SRL, SRA or ROR.
// Ports       : acc  in  WIDTH    value being shifted
//               mode in  2        shift mode (MODE_* encodings)
//               k    in  SHAMT_W  bit positions to shift this cycle
//               res  out WIDTH    shifted value
// Revision    : 1.0 - initial release
// ============================================================================
module ee357_iter_shifter_step
  import ee357_iter_shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input  logic [WIDTH-1:0]   acc,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] k,
  output logic [WIDTH-1:0]   res
);

  generate
    if (STEP == 1) begin : g_step_single
      // Single-bit stage: k is 0 or 1, so a plain 2:1 choice per mode.
      always_comb begin
        res = acc;
        if (k != '0) begin
          case (mode)
            MODE_SLL: res = {acc[WIDTH-2:0], 1'b0};
            MODE_SRL: res = {1'b0, acc[WIDTH-1:1]};
            MODE_SRA: res = {acc[WIDTH-1], acc[WIDTH-1:1]};
            default:  res = {acc[0], acc[WIDTH-1:1]};
          endcase
        end
      end
    end else begin : g_step_multi
      localparam logic [SHAMT_W:0] c_width = WIDTH[SHAMT_W:0];

      logic signed [WIDTH-1:0] w_sra;
      logic        [SHAMT_W:0] w_rot_amt;

      assign w_sra     = $signed(acc) >>> k;
      // Rotate right by k == (acc >> k) | (acc << (WIDTH-k)); k=0 makes the
      // left term vanish, leaving acc unchanged.
      assign w_rot_amt = c_width - {1'b0, k};

      always_comb begin
        res = acc;
        case (mode)
          MODE_SLL: res = acc << k;
          MODE_SRL: res = acc >> k;
          MODE_SRA: res = w_sra;
          default:  res = (acc >> k) | (acc << w_rot_amt);
        endcase
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ee357_iter_shifter.sv
`default_nettype none
// ============================================================================
// Module      : ee357_iter_shifter
// Description : Multicycle shifter. Accepts an operand, shift amount and mode
//               under a start handshake, shifts STEP bits per clock and
//               pulses done for one cycle with the result on out.
// Ports       : clk   in  1        rising-edge clock
//               rst_n in  1        synchronous active-low reset
//               start in  1        request, accepted in IDLE or DONE only
//               mode  in  2        0=SLL 1=SRL 2=SRA 3=ROR, sampled on accept
//               shamt in  SHAMT_W  shift amount, sampled on accept
//               in    in  WIDTH    operand, sampled on accept
//               busy  out 1        high while shifting
//               done  out 1        one-cycle pulse, out valid
//               out   out WIDTH    result, held until the next result
// Revision    : 1.0 - initial release
// ============================================================================
module ee357_iter_shifter
  import ee357_iter_shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out
);

  localparam logic [31:0] c_step = STEP;

  state_t             r_state;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_rem;
  logic [1:0]         r_mode;
  logic [WIDTH-1:0]   r_out;

  state_t             w_state_next;
  logic [WIDTH-1:0]   w_acc_next;
  logic [SHAMT_W-1:0] w_rem_next;
  logic [1:0]         w_mode_next;
  logic               w_load_out;
  logic [WIDTH-1:0]   w_out_next;
  logic               w_accept;
  logic [SHAMT_W-1:0] w_k;
  logic [WIDTH-1:0]   w_shifted;

  // k = min(STEP, rem). rem never exceeds WIDTH-1, so whenever STEP is
  // chosen it fits in SHAMT_W bits.
  always_comb begin
    w_k = r_rem;
    if (32'(r_rem) >= c_step) begin
      w_k = c_step[SHAMT_W-1:0];
    end
  end

  ee357_iter_shifter_step #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .STEP    (STEP)
  ) u_step (
    .acc  (r_acc),
    .mode (r_mode),
    .k    (w_k),
    .res  (w_shifted)
  );

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Next-state and datapath next values
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_rem_next   = r_rem;
    w_mode_next  = r_mode;
    w_load_out   = 1'b0;
    w_out_next   = r_acc;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_state_next = ST_IDLE;
        if (w_accept) begin
          w_acc_next  = in;
          w_mode_next = mode;
          w_rem_next  = shamt;
          if (shamt != '0) begin
            w_state_next = ST_SHIFT;
          end else begin
            // Zero shift goes straight to DONE with the operand as result
            w_state_next = ST_DONE;
            w_load_out   = 1'b1;
            w_out_next   = in;
          end
        end
      end
      ST_SHIFT: begin
        // start is ignored here: nothing below looks at the request inputs
        w_acc_next = w_shifted;
        w_rem_next = r_rem - w_k;
        if (r_rem == w_k) begin
          w_state_next = ST_DONE;
          w_load_out   = 1'b1;
          w_out_next   = w_shifted;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_mode  <= MODE_SLL;
      r_out   <= '0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_rem   <= w_rem_next;
      r_mode  <= w_mode_next;
      if (w_load_out) begin
        r_out <= w_out_next;
      end
    end
  end

  // out is loaded on entry to DONE, so it is valid for the whole done pulse
  assign busy = (r_state == ST_SHIFT);
  assign done = (r_state == ST_DONE);
  assign out  = r_out;

endmodule
`default_nettype wire

// File: tb/tb_ee357_iter_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ee357_iter_shifter
// Description : Directed self-checking bench for ee357_iter_shifter, using a
//               STEP=1 instance and a STEP=4 instance (WIDTH=32 both).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ee357_iter_shifter;

  localparam logic [1:0] SLL = 2'd0;
  localparam logic [1:0] SRL = 2'd1;
  localparam logic [1:0] SRA = 2'd2;
  localparam logic [1:0] ROR = 2'd3;

  logic        clk;
  logic        rst_n;

  logic        start1, start4;
  logic [1:0]  mode1, mode4;
  logic [4:0]  shamt1, shamt4;
  logic [31:0] in1, in4;
  logic        busy1, busy4;
  logic        done1, done4;
  logic [31:0] out1, out4;

  int n_checks;
  int n_errors;

  ee357_iter_shifter #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .mode  (mode1),
    .shamt (shamt1),
    .in    (in1),
    .busy  (busy1),
    .done  (done1),
    .out   (out1)
  );

  ee357_iter_shifter #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .mode  (mode4),
    .shamt (shamt4),
    .in    (in4),
    .busy  (busy4),
    .done  (done4),
    .out   (out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int sel, input logic st, input logic [1:0] m,
                       input logic [4:0] sa, input logic [31:0] d);
    if (sel == 0) begin
      start1 = st; mode1 = m; shamt1 = sa; in1 = d;
    end else begin
      start4 = st; mode4 = m; shamt4 = sa; in4 = d;
    end
  endtask

  // One request on the selected instance; cycle 1 is the cycle after the
  // accepting edge. Checks latency, result, busy/done exclusivity and hold.
  task automatic run_op(input int sel, input logic [1:0] m, input logic [4:0] sa,
                        input logic [31:0] d, input logic [31:0] exp_out,
                        input int exp_lat, input string name);
    int lat;
    logic b, dn;
    logic [31:0] o;
    lat = 0;
    @(negedge clk);
    drive(sel, 1'b1, m, sa, d);
    @(negedge clk);
    drive(sel, 1'b0, m, sa, d);
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      b  = (sel == 0) ? busy1 : busy4;
      dn = (sel == 0) ? done1 : done4;
      n_checks++;
      if (b && dn) begin
        n_errors++;
        $display("FAIL %s busy_done_overlap: cycle %0d busy=%b done=%b, required not both", name, c, b, dn);
      end
      if (dn) lat = c;
    end
    o = (sel == 0) ? out1 : out4;
    n_checks++;
    if (lat !== exp_lat) begin
      n_errors++;
      $display("FAIL %s latency: got %0d, expected %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (o !== exp_out) begin
      n_errors++;
      $display("FAIL %s out: got %h, expected %h", name, o, exp_out);
    end
    @(negedge clk);
    dn = (sel == 0) ? done1 : done4;
    o  = (sel == 0) ? out1 : out4;
    n_checks++;
    if (dn !== 1'b0 || o !== exp_out) begin
      n_errors++;
      $display("FAIL %s hold: done=%b out=%h, expected done=0 out=%h", name, dn, o, exp_out);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, SLL, 5'd0, 32'h0);
    drive(1, 1'b0, SLL, 5'd0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || out1 !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_step1: busy=%b done=%b out=%h, expected 0 0 00000000", busy1, done1, out1);
    end
    n_checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || out4 !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_step4: busy=%b done=%b out=%h, expected 0 0 00000000", busy4, done4, out4);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sll();
    run_op(0, SLL, 5'd2, 32'h0000_0003, 32'h0000_000C, 3, "sll_basic");
    run_op(0, SLL, 5'd2, 32'hC000_0000, 32'h0000_0000, 3, "sll_discard");
    run_op(1, SLL, 5'd5, 32'h0000_0001, 32'h0000_0020, 3, "sll_step4_partial");
  endtask

  task automatic test_right_shifts();
    run_op(1, SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 9, "sra_step4_31");
    run_op(1, SRL, 5'd31, 32'h8000_0000, 32'h0000_0001, 9, "srl_step4_31");
    run_op(0, SRA, 5'd4,  32'hF000_0000, 32'hFF00_0000, 5, "sra_neg");
    run_op(0, SRA, 5'd3,  32'h7000_0000, 32'h0E00_0000, 4, "sra_pos");
  endtask

  task automatic test_ror();
    run_op(0, ROR, 5'd1, 32'h0000_0001, 32'h8000_0000, 2, "ror_wrap");
    run_op(0, ROR, 5'd4, 32'h1234_5678, 32'h8123_4567, 5, "ror_nibble");
    run_op(1, ROR, 5'd8, 32'h1234_5678, 32'h7812_3456, 3, "ror_step4_byte");
  endtask

  task automatic test_zero_shamt();
    run_op(0, SLL, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, "zero_sll");
    run_op(1, SRA, 5'd0, 32'h8000_0001, 32'h8000_0001, 1, "zero_sra_step4");
  endtask

  // start while busy is ignored; start in the DONE cycle is accepted,
  // both into SHIFT and straight into DONE again.
  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    drive(0, 1'b1, SLL, 5'd8, 32'h0000_0001);
    @(negedge clk);
    drive(0, 1'b0, SLL, 5'd8, 32'h0000_0001);
    lat = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 3) drive(0, 1'b1, SRA, 5'd1, 32'hFFFF_FFFF);
      else        drive(0, 1'b0, SLL, 5'd0, 32'h0);
      if (c == 4) begin
        n_checks++;
        if (busy1 !== 1'b1) begin
          n_errors++;
          $display("FAIL ignore_busy: busy=%b after start in SHIFT, expected 1", busy1);
        end
      end
      if (done1) lat = c;
    end
    n_checks++;
    if (lat !== 9 || out1 !== 32'h0000_0100) begin
      n_errors++;
      $display("FAIL ignore_result: latency %0d out %h, expected 9 00000100", lat, out1);
    end
    // still in the DONE cycle: issue the next request
    drive(0, 1'b1, SRL, 5'd4, 32'h0000_00F0);
    @(negedge clk);
    drive(0, 1'b0, SLL, 5'd0, 32'h0);
    n_checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      n_errors++;
      $display("FAIL done_accept: busy=%b done=%b, expected busy=1 done=0", busy1, done1);
    end
    lat = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (done1) lat = c;
    end
    n_checks++;
    if (lat !== 5 || out1 !== 32'h0000_000F) begin
      n_errors++;
      $display("FAIL b2b_result: latency %0d out %h, expected 5 0000000f", lat, out1);
    end
    drive(0, 1'b1, ROR, 5'd0, 32'h0000_0055);
    @(negedge clk);
    drive(0, 1'b0, SLL, 5'd0, 32'h0);
    n_checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || out1 !== 32'h0000_0055) begin
      n_errors++;
      $display("FAIL b2b_zero: done=%b busy=%b out=%h, expected 1 0 00000055", done1, busy1, out1);
    end
    @(negedge clk);
    n_checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_idle: done=%b busy=%b, expected 0 0", done1, busy1);
    end
  endtask

  // Reset in the middle of an 8-cycle shift aborts it without a done pulse.
  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    drive(0, 1'b1, SLL, 5'd8, 32'h0000_0001);
    @(negedge clk);
    drive(0, 1'b0, SLL, 5'd0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || out1 !== 32'h0) begin
      n_errors++;
      $display("FAIL abort_state: busy=%b done=%b out=%h, expected 0 0 00000000", busy1, done1, out1);
    end
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done1 || busy1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_errors++;
      $display("FAIL abort_no_done: %0d cycles with busy/done, expected 0", seen);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_sll();
    test_right_shifts();
    test_ror();
    test_zero_shamt();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
